// File: rtl/asc2ps2_pkg.sv
// rtl/asc2ps2_pkg.sv - shared types, constants and ASCII-to-set-2 lookup for asc2ps2_tx
// Contents: state_e FSM encoding, SC_BREAK / SC_LSHIFT prefix codes, SEQ_LEN bytes per
// character, and asc2sc() returning {hit, code[7:0]}.
// Optional feature macro: ASC2PS2_SHIFT_EN (uppercase mapping plus left-shift wrapping).
package asc2ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;

`ifdef ASC2PS2_SHIFT_EN
    localparam int SEQ_LEN = 6;
`else
    localparam int SEQ_LEN = 3;
`endif

    localparam logic [7:0] ALPHA_SC [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };

    localparam logic [7:0] DIGIT_SC [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };

    // Returns {hit, code}; hit=0 means the character has no set-2 mapping.
    function automatic logic [8:0] asc2sc(input logic [7:0] a);
        logic [8:0] r;
        logic [7:0] off;
        r   = '0;
        off = '0;
        if (a >= 8'h61 && a <= 8'h7A) begin
            off = a - 8'h61;
            r   = {1'b1, ALPHA_SC[off[4:0]]};
`ifdef ASC2PS2_SHIFT_EN
        end else if (a >= 8'h41 && a <= 8'h5A) begin
            off = a - 8'h41;
            r   = {1'b1, ALPHA_SC[off[4:0]]};
`endif
        end else if (a >= 8'h30 && a <= 8'h39) begin
            off = a - 8'h30;
            r   = {1'b1, DIGIT_SC[off[3:0]]};
        end else begin
            case (a)
                8'h20:   r = {1'b1, 8'h29};
                8'h0D:   r = {1'b1, 8'h5A};
                8'h08:   r = {1'b1, 8'h66};
                8'h09:   r = {1'b1, 8'h0D};
                8'h1B:   r = {1'b1, 8'h76};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/asc2ps2_tx_if.sv
// rtl/asc2ps2_tx_if.sv - character handshake, status and PS/2 line bundle for asc2ps2_tx
// Signals: asc/asc_valid/asc_ready character handshake; busy, err, sent status;
// ps2_clk/ps2_data device-driven PS/2 lines (idle high).
// Modports: dev (the transmitter), host (the character source / line observer).
interface asc2ps2_tx_if;
    logic [7:0] asc;
    logic       asc_valid;
    logic       asc_ready;
    logic       busy;
    logic       err;
    logic       sent;
    logic       ps2_clk;
    logic       ps2_data;

    modport dev (
        input  asc, asc_valid,
        output asc_ready, busy, err, sent, ps2_clk, ps2_data
    );

    modport host (
        output asc, asc_valid,
        input  asc_ready, busy, err, sent, ps2_clk, ps2_data
    );
endinterface

// File: rtl/asc2ps2_tx_frame.sv
// rtl/asc2ps2_tx_frame.sv - ps2_frame_tx: serializes one byte as an 11-bit PS/2 device frame
// Ports: clk_i, rst_i (sync active-high), start_i loads byte_i and begins a frame,
// ps2_clk_o / ps2_data_o line outputs (idle high), done_o high on the frame's last cycle.
// Each bit spends CLK_DIV cycles with ps2_clk high (data changes here) then CLK_DIV low.
module ps2_frame_tx #(
    parameter int CLK_DIV = 2500
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       ps2_clk_o,
    output logic       ps2_data_o,
    output logic       done_o
);
    localparam int             DW       = $clog2(2 * CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0]  DIV_HALF = DW'(CLK_DIV);

    logic          active_q, active_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic [10:0]   frame_q, frame_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            frame_q  <= '1;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
        end
    end

    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        if (start_i) begin
            // stop, odd parity, data LSB-first, start: bit_q indexes in send order
            active_d = 1'b1;
            div_d    = '0;
            bit_d    = '0;
            frame_d  = {1'b1, ~^byte_i, byte_i, 1'b0};
        end else if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (bit_q == 4'd10) begin
                    active_d = 1'b0;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    assign ps2_clk_o  = ~active_q | (div_q < DIV_HALF);
    assign ps2_data_o = ~active_q | frame_q[bit_q];
    assign done_o     = active_q && (div_q == DIV_LAST) && (bit_q == 4'd10);

endmodule

// File: rtl/asc2ps2_tx.sv
// rtl/asc2ps2_tx.sv - keyboard-side PS/2 transmitter: ASCII in, set-2 make/break frames out
// Ports: clk_i, rst_i (sync active-high), bus (asc2ps2_tx_if.dev: asc handshake,
// busy/err/sent status, ps2_clk/ps2_data lines).
// Owns the sequencing FSM, byte index and inter-byte gap counter; ps2_frame_tx does bits.
// Optional feature macro: ASC2PS2_SHIFT_EN (uppercase accepted, sequence wrapped in left shift).
module asc2ps2_tx
    import asc2ps2_pkg::*;
#(
    parameter int CLK_DIV = 2500,
    parameter int GAP_CYC = 5000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    asc2ps2_tx_if.dev    bus
);
    localparam int            GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [2:0]    SEQ_LAST = 3'(SEQ_LEN - 1);

    state_e        state_q, state_d;
    logic [7:0]    code_q, code_d;
    logic [2:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;

    logic       frame_start;
    logic [7:0] frame_byte;
    logic       frame_done;
    logic [8:0] lookup;

    // Byte at position idx of the make/break sequence for scancode code.
    function automatic logic [7:0] seq_byte(input logic [2:0] idx, input logic [7:0] code);
`ifdef ASC2PS2_SHIFT_EN
        case (idx)
            3'd0:    return SC_LSHIFT;
            3'd1:    return code;
            3'd2:    return SC_BREAK;
            3'd3:    return code;
            3'd4:    return SC_BREAK;
            default: return SC_LSHIFT;
        endcase
`else
        return (idx == 3'd1) ? SC_BREAK : code;
`endif
    endfunction

    assign lookup = asc2sc(bus.asc);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        frame_start = 1'b0;
        frame_byte  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.asc_valid) begin
                    if (lookup[8]) begin
                        // first frame is launched in the accept cycle so bits begin at T+1
                        code_d      = lookup[7:0];
                        idx_d       = '0;
                        frame_start = 1'b1;
                        frame_byte  = seq_byte(3'd0, lookup[7:0]);
                        state_d     = ST_FRAME;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_FRAME: begin
                if (frame_done) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (idx_q == SEQ_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d       = idx_q + 3'd1;
                        frame_start = 1'b1;
                        frame_byte  = seq_byte(idx_q + 3'd1, code_q);
                        state_d     = ST_FRAME;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    ps2_frame_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (frame_start),
        .byte_i     (frame_byte),
        .ps2_clk_o  (bus.ps2_clk),
        .ps2_data_o (bus.ps2_data),
        .done_o     (frame_done)
    );

    assign bus.asc_ready = (state_q == ST_IDLE) && !rst_i;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.sent      = (state_q == ST_DONE);
    assign bus.err       = (state_q == ST_ERR);

endmodule
